// File: rtl/lcd_read_engine.sv
// lcd_read_engine
// Read-side companion to the LCD write controller on the 4-bit character-LCD
// bus. Performs HD44780-style 4-bit read cycles: busy flag + address (RS=0) or
// DD/CG RAM data (RS=1). Optionally re-reads the busy flag until it clears.
// The top level gives this block the pads whenever ready_o=0.
//
// Ports:
//   clk_i        system clock (50 MHz)
//   rst_n_i      synchronous active-low reset
//   req_i        start a read (accepted only while ready_o=1)
//   req_rs_i     RS for the read, sampled at accept
//   poll_i       poll busy flag until clear (only with req_rs_i=0)
//   ready_o      idle, can accept req_i
//   rdata_o      assembled byte {upper nibble, lower nibble}
//   rvalid_o     one-cycle pulse, rdata_o/timeout_o valid
//   timeout_o    poll ended with busy still set
//   lcd_d_in_i   SF_D[11:8] from pad input buffer
//   lcd_d_oe_o   1 = FPGA may drive SF_D (never while RW=1)
//   control_o    {LCD_E, LCD_RS, LCD_RW}
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_RELEASE | bus released, one cycle before idle
// S_IDLE    | ready, writer may drive the data pads
// S_TURN    | pad driver off, turnaround before RW rises
// S_SETUP   | RS/RW setup before first E rise
// S_E_HI    | E high, nibble captured on the last cycle's edge
// S_GAP     | E low between nibbles / between polled reads
// S_HOLD    | RS/RW hold after the final E fall
// S_DONE    | decide: poll again or finish
module lcd_read_engine #(
    parameter int SETUP_CYC  = 2,
    parameter int E_HIGH_CYC = 12,
    parameter int GAP_CYC    = 50,
    parameter int HOLD_CYC   = 2,
    parameter int POLL_MAX   = 255
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       req_i,
    input  logic       req_rs_i,
    input  logic       poll_i,
    output logic       ready_o,
    output logic [7:0] rdata_o,
    output logic       rvalid_o,
    output logic       timeout_o,
    input  logic [3:0] lcd_d_in_i,
    output logic       lcd_d_oe_o,
    output logic [2:0] control_o
);

    localparam int CW = 16;

    typedef enum logic [2:0] {
        S_RELEASE, S_IDLE, S_TURN, S_SETUP, S_E_HI, S_GAP, S_HOLD, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            nib_q, nib_d;
    logic            rs_q, rs_d;
    logic            poll_q, poll_d;
    logic [7:0]      att_q, att_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            timeout_q, timeout_d;
    logic            cmpl_q, cmpl_d;
    logic [2:0]      ctrl_q, ctrl_d;
    logic            oe_q, oe_d;
    logic            ready_q, ready_d;
    logic            rvalid_q, rvalid_d;
    logic            rw_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nib_d     = nib_q;
        rs_d      = rs_q;
        poll_d    = poll_q;
        att_d     = att_q;
        rdata_d   = rdata_q;
        timeout_d = timeout_q;
        cmpl_d    = cmpl_q;

        case (state_q)
            S_RELEASE: state_d = S_IDLE;
            S_IDLE: begin
                att_d  = '0;
                nib_d  = 1'b0;
                cmpl_d = 1'b0;
                if (req_i) begin
                    rs_d      = req_rs_i;
                    poll_d    = poll_i & ~req_rs_i;
                    timeout_d = 1'b0;
                    state_d   = S_TURN;
                end
            end
            S_TURN: begin
                state_d = S_SETUP;
                cnt_d   = CW'(SETUP_CYC - 1);
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_E_HI;
                    cnt_d   = CW'(E_HIGH_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_E_HI: begin
                if (cnt_q == '0) begin
                    // Data is sampled on the same edge that drops E.
                    if (nib_q) begin
                        rdata_d = {rdata_q[7:4], lcd_d_in_i};
                        state_d = S_HOLD;
                        cnt_d   = CW'(HOLD_CYC - 1);
                    end else begin
                        rdata_d = {lcd_d_in_i, rdata_q[3:0]};
                        state_d = S_GAP;
                        cnt_d   = CW'(GAP_CYC - 1);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    nib_d   = ~nib_q;
                    state_d = S_E_HI;
                    cnt_d   = CW'(E_HIGH_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    att_d   = att_q + 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (poll_q && rdata_q[7] && (att_q < 8'(POLL_MAX))) begin
                    // Index set to 1 so the gap's toggle starts at the upper nibble.
                    nib_d   = 1'b1;
                    state_d = S_GAP;
                    cnt_d   = CW'(GAP_CYC - 1);
                end else begin
                    timeout_d = poll_q & rdata_q[7];
                    cmpl_d    = 1'b1;
                    state_d   = S_RELEASE;
                end
            end
            default: state_d = S_RELEASE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        rw_d     = (state_d == S_SETUP) || (state_d == S_E_HI) || (state_d == S_GAP) ||
                   (state_d == S_HOLD)  || (state_d == S_DONE);
        ctrl_d   = {state_d == S_E_HI, rs_d & rw_d, rw_d};
        oe_d     = (state_d == S_IDLE);
        ready_d  = (state_d == S_IDLE);
        rvalid_d = (state_q == S_RELEASE) && cmpl_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= S_RELEASE;
            cnt_q     <= '0;
            nib_q     <= 1'b0;
            rs_q      <= 1'b0;
            poll_q    <= 1'b0;
            att_q     <= '0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
            cmpl_q    <= 1'b0;
            ctrl_q    <= '0;
            oe_q      <= 1'b0;
            ready_q   <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nib_q     <= nib_d;
            rs_q      <= rs_d;
            poll_q    <= poll_d;
            att_q     <= att_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
            cmpl_q    <= cmpl_d;
            ctrl_q    <= ctrl_d;
            oe_q      <= oe_d;
            ready_q   <= ready_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign control_o  = ctrl_q;
    assign lcd_d_oe_o = oe_q;
    assign ready_o    = ready_q;
    assign rvalid_o   = rvalid_q;
    assign rdata_o    = rdata_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_lcd_read_engine.sv
// Testbench for lcd_read_engine: a default-parameter instance for most tests
// and a POLL_MAX=2 instance for the poll timeout case. A small LCD model
// returns table bytes nibble by nibble, advancing on each E fall.
module tb_lcd_read_engine;

    logic       clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       req = 1'b0, req_rs = 1'b0, poll = 1'b0;
    logic       ready, rvalid, timeout, oe;
    logic [7:0] rdata;
    logic [2:0] control;
    logic [3:0] lcd_d;

    logic       req1 = 1'b0, rs1 = 1'b0, poll1 = 1'b1;
    logic       ready1, rvalid1, timeout1, oe1;
    logic [7:0] rdata1;
    logic [2:0] control1;
    logic [3:0] lcd_d1;

    lcd_read_engine dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .req_rs_i(req_rs), .poll_i(poll),
        .ready_o(ready), .rdata_o(rdata), .rvalid_o(rvalid), .timeout_o(timeout),
        .lcd_d_in_i(lcd_d), .lcd_d_oe_o(oe), .control_o(control)
    );

    lcd_read_engine #(.POLL_MAX(2)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req1), .req_rs_i(rs1), .poll_i(poll1),
        .ready_o(ready1), .rdata_o(rdata1), .rvalid_o(rvalid1), .timeout_o(timeout1),
        .lcd_d_in_i(lcd_d1), .lcd_d_oe_o(oe1), .control_o(control1)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // LCD model for dut: byte table, nibble index toggles on each E fall.
    logic [7:0] resp0 [8];
    int         bidx = 0;
    logic       nib0 = 1'b0;
    logic       e_prev0 = 1'b0;
    logic       model_clr = 1'b1;

    always @(posedge clk) begin
        e_prev0 <= control[2];
        if (model_clr) begin
            bidx <= 0;
            nib0 <= 1'b0;
        end else if (e_prev0 && !control[2]) begin
            nib0 <= ~nib0;
            if (nib0 && bidx < 7) bidx <= bidx + 1;
        end
    end
    assign lcd_d = nib0 ? resp0[bidx][3:0] : resp0[bidx][7:4];

    // dut1 model: always busy, returns 0x80.
    logic nib1 = 1'b0;
    logic e_prev1 = 1'b0;
    always @(posedge clk) begin
        e_prev1 <= control1[2];
        if (e_prev1 && !control1[2]) nib1 <= ~nib1;
    end
    assign lcd_d1 = nib1 ? 4'h0 : 4'h8;

    // Bus-safety monitor on both instances.
    logic [2:0] cp0 = '0, cp1 = '0;
    logic       op0 = 1'b0, op1 = 1'b0;

    function automatic logic bus_bad(input logic [2:0] c, input logic o,
                                     input logic [2:0] cp, input logic op);
        logic v;
        v = 1'b0;
        if (o && (c[0] || cp[0])) v = 1'b1;                        // oe with RW now or last cycle
        if (c[0] && !cp[0] && op) v = 1'b1;                        // oe the cycle before RW rises
        if (c[2] && !cp[2] && (c[1:0] != cp[1:0])) v = 1'b1;       // E rise with RS/RW change
        if (c[0] && cp[0] && (c[1] != cp[1])) v = 1'b1;            // RS change while RW held
        return v;
    endfunction

    always @(negedge clk) begin
        chk("bus_safety0", bus_bad(control, oe, cp0, op0), 0);
        chk("bus_safety1", bus_bad(control1, oe1, cp1, op1), 0);
        cp0 <= control;
        op0 <= oe;
        cp1 <= control1;
        op1 <= oe1;
    end

    typedef struct {
        string      nm;
        logic       rs;
        logic       pl;
        logic [7:0] resp [4];
        int         exp_cyc;
        logic [7:0] exp_d;
        logic       exp_to;
        int         exp_pulses;
    } vec_t;

    vec_t vecs [5];

    task automatic clear_model();
        @(negedge clk);
        model_clr = 1'b1;
        @(negedge clk);
        model_clr = 1'b0;
    endtask

    // One read on dut; stimulus placed at a negedge, accept edge = cycle 0.
    task automatic do_read(input vec_t v);
        int   k, hi, pulses, first_gap, low_run, extra;
        logic seen, bad_w, bad_rs;
        for (int i = 0; i < 4; i++) resp0[i] = v.resp[i];
        for (int i = 4; i < 8; i++) resp0[i] = 8'h00;
        clear_model();
        chk({v.nm, "_ready_before"}, ready, 1);
        req = 1'b1; req_rs = v.rs; poll = v.pl;
        @(negedge clk);
        req = 1'b0;
        k = 1; seen = 0; hi = 0; pulses = 0; first_gap = -1; low_run = 0;
        bad_w = 0; bad_rs = 0;
        while (!seen && k < 2000) begin
            if (control[2]) begin
                if (control[1] !== v.rs) bad_rs = 1;
                if (low_run > 0 && pulses == 1 && first_gap < 0) first_gap = low_run;
                hi++;
                low_run = 0;
            end else begin
                if (hi > 0) begin
                    pulses++;
                    if (hi != 12) bad_w = 1;
                end
                hi = 0;
                low_run++;
            end
            req = (k == 40);
            if (rvalid) seen = 1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        req = 1'b0;
        chk({v.nm, "_rvalid_cycle"}, seen ? k : 0, v.exp_cyc);
        chk({v.nm, "_rdata"}, rdata, v.exp_d);
        chk({v.nm, "_timeout"}, timeout, v.exp_to);
        chk({v.nm, "_e_pulses"}, pulses, v.exp_pulses);
        chk({v.nm, "_e_width"}, bad_w, 0);
        chk({v.nm, "_rs_during_e"}, bad_rs, 0);
        chk({v.nm, "_first_gap"}, first_gap, 50);
        extra = 0;
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            if (rvalid) extra++;
        end
        chk({v.nm, "_no_second_rvalid"}, extra, 0);
        chk({v.nm, "_ready_after"}, ready, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k, n;
        logic seen;

        vecs[0] = '{"rs1_single",   1'b1, 1'b0, '{8'h41, 8'h00, 8'h00, 8'h00},  82, 8'h41, 1'b0, 2};
        vecs[1] = '{"rs0_nopoll",   1'b0, 1'b0, '{8'hA3, 8'h00, 8'h00, 8'h00},  82, 8'hA3, 1'b0, 2};
        vecs[2] = '{"rs1_pollign",  1'b1, 1'b1, '{8'h9C, 8'h00, 8'h00, 8'h00},  82, 8'h9C, 1'b0, 2};
        vecs[3] = '{"poll_4reads",  1'b0, 1'b1, '{8'h80, 8'h8F, 8'h85, 8'h05}, 463, 8'h05, 1'b0, 8};
        vecs[4] = '{"poll_notbusy", 1'b0, 1'b1, '{8'h12, 8'h00, 8'h00, 8'h00},  82, 8'h12, 1'b0, 2};

        // Reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_control", control, 0);
            chk("rst_oe", oe, 0);
            chk("rst_ready", ready, 0);
            chk("rst_rdata", rdata, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_idle_ready", ready, 1);
        chk("first_idle_oe", oe, 1);
        chk("first_idle_ready1", ready1, 1);

        // Reset in the middle of the first E-high window
        resp0[0] = 8'h41;
        clear_model();
        req = 1'b1; req_rs = 1'b1; poll = 1'b0;
        @(negedge clk);
        req = 1'b0;
        for (int i = 1; i < 8; i++) @(negedge clk);
        chk("midrst_e_high", control[2], 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_control", control, 0);
        chk("midrst_oe", oe, 0);
        chk("midrst_ready", ready, 0);
        n = (rvalid === 1'b1) ? 1 : 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rvalid) n++;
        end
        chk("midrst_no_rvalid", n, 0);
        chk("midrst_ready_after", ready, 1);

        // Table-driven reads
        for (int i = 0; i < 5; i++) do_read(vecs[i]);

        // Back-to-back: req held high is re-accepted in the rvalid cycle
        resp0[0] = 8'h41; resp0[1] = 8'h7E;
        clear_model();
        req = 1'b1; req_rs = 1'b1; poll = 1'b0;
        k = 0; seen = 0;
        while (!seen && k < 1000) begin
            @(negedge clk);
            k++;
            if (rvalid) seen = 1;
        end
        chk("b2b_first_cycle", seen ? k : 0, 82);
        chk("b2b_first_rdata", rdata, 8'h41);
        chk("b2b_ready_in_rvalid", ready, 1);
        @(negedge clk);
        k++;
        req = 1'b0;
        chk("b2b_reaccepted", ready, 0);
        chk("b2b_rvalid_pulse", rvalid, 0);
        seen = 0;
        while (!seen && k < 1000) begin
            @(negedge clk);
            k++;
            if (rvalid) seen = 1;
        end
        chk("b2b_second_cycle", seen ? k : 0, 164);
        chk("b2b_second_rdata", rdata, 8'h7E);

        // Poll timeout on the POLL_MAX=2 instance
        @(negedge clk);
        req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        k = 1; seen = 0;
        while (!seen && k < 1000) begin
            if (rvalid1) seen = 1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        chk("timeout_cycle", seen ? k : 0, 209);
        chk("timeout_rdata", rdata1, 8'h80);
        chk("timeout_flag", timeout1, 1);
        @(negedge clk);
        chk("timeout_rvalid_pulse", rvalid1, 0);
        chk("timeout_flag_held", timeout1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
